// File: rtl/logic16_pkg.sv
// Shared definitions for the two-requester logic arbiter: default width, op codes, controller states.
// XOR support is selected with the LOGIC16_XOR_EN macro in logic16_unit.
package logic16_pkg;

    localparam int WIDTH_DEFAULT = 16;

    typedef enum logic [1:0] {
        OP_NOT = 2'd0,
        OP_AND = 2'd1,
        OP_OR  = 2'd2,
        OP_XOR = 2'd3
    } op_e;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

endpackage

// File: rtl/logic16_unit.sv
// Combinational bitwise logic unit (y = op(a, b)).
// Macro LOGIC16_XOR_EN: defined -> op 3 is a^b; undefined -> op 3 falls back to NOT a.
module logic16_unit
    import logic16_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    logic is_and;
    logic is_or;
    logic is_xor;

    assign is_and = (op == OP_AND);
    assign is_or  = (op == OP_OR);
`ifdef LOGIC16_XOR_EN
    assign is_xor = (op == OP_XOR);
`else
    assign is_xor = 1'b0;
`endif

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
`ifdef LOGIC16_XOR_EN
            assign y[gi] = is_and ? (a[gi] & b[gi]) :
                           is_or  ? (a[gi] | b[gi]) :
                           is_xor ? (a[gi] ^ b[gi]) :
                                    ~a[gi];
`else
            // op 3 deliberately shares the NOT path when XOR is disabled
            assign y[gi] = is_and ? (a[gi] & b[gi]) :
                           is_or  ? (a[gi] | b[gi]) :
                                    ~a[gi];
`endif
        end
    endgenerate

`ifndef LOGIC16_XOR_EN
    logic unused_xor;
    assign unused_xor = is_xor;
`endif

endmodule

// File: rtl/logic16_arbiter.sv
// Round-robin arbiter sharing one logic16_unit between two requesters, one-deep registered output.
// Optional XOR operation enabled by macro LOGIC16_XOR_EN (see logic16_unit).
module logic16_arbiter
    import logic16_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in0_valid,
    output logic             in0_ready,
    input  logic [1:0]       in0_op,
    input  logic [WIDTH-1:0] in0_a,
    input  logic [WIDTH-1:0] in0_b,
    input  logic             in1_valid,
    output logic             in1_ready,
    input  logic [1:0]       in1_op,
    input  logic [WIDTH-1:0] in1_a,
    input  logic [WIDTH-1:0] in1_b,
    output logic [WIDTH-1:0] out,
    output logic             out_id,
    output logic             out_valid,
    input  logic             out_ready
);

    state_e           state_reg, state_next;
    logic             ptr_reg, ptr_next;
    logic [WIDTH-1:0] out_reg;
    logic             out_id_reg;

    logic             can_accept;
    logic             grant1;
    logic             accept;
    logic [1:0]       sel_op;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [WIDTH-1:0] unit_y;

    assign can_accept = (state_reg == ST_EMPTY) || out_ready;
    // Requester 1 wins when it is alone or when both are valid and it is preferred
    assign grant1     = in1_valid && (!in0_valid || ptr_reg);
    // Reset blocks any handshake even though the state is already cleared asynchronously
    assign accept     = can_accept && (in0_valid || in1_valid) && !rst;
    assign in0_ready  = accept && !grant1;
    assign in1_ready  = accept && grant1;

    assign sel_op = grant1 ? in1_op : in0_op;
    assign sel_a  = grant1 ? in1_a  : in0_a;
    assign sel_b  = grant1 ? in1_b  : in0_b;

    logic16_unit #(.WIDTH(WIDTH)) u_unit (
        .op (sel_op),
        .a  (sel_a),
        .b  (sel_b),
        .y  (unit_y)
    );

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        case (state_reg)
            ST_EMPTY: if (accept) state_next = ST_FULL;
            ST_FULL:  if (!accept && out_ready) state_next = ST_EMPTY;
            default:  state_next = ST_EMPTY;
        endcase
        if (accept) begin
            ptr_next = !grant1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= ST_EMPTY;
            ptr_reg    <= 1'b0;
            out_reg    <= '0;
            out_id_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            if (accept) begin
                out_reg    <= unit_y;
                out_id_reg <= grant1;
            end
        end
    end

    assign out       = out_reg;
    assign out_id    = out_id_reg;
    assign out_valid = (state_reg == ST_FULL);

endmodule

// File: tb/tb_logic16_arbiter.sv
// Self-checking bench for logic16_arbiter: directed scenarios plus randomized traffic against a
// transaction-level reference model. Honors LOGIC16_XOR_EN the same way as the design.
module tb_logic16_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        in0_valid, in1_valid;
    logic        in0_ready, in1_ready;
    logic [1:0]  in0_op, in1_op;
    logic [15:0] in0_a, in0_b, in1_a, in1_b;
    logic [15:0] out;
    logic        out_id, out_valid;
    logic        out_ready;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: result slot, its owner, and which requester is preferred next
    bit          m_full;
    logic [15:0] m_out;
    bit          m_id;
    bit          m_ptr;
    bit          last_r0, last_r1;

`ifdef LOGIC16_XOR_EN
    localparam logic [15:0] XOR_EXP1 = 16'h5D4C;
    localparam logic [15:0] XOR_EXP2 = 16'hA2B3;
`else
    localparam logic [15:0] XOR_EXP1 = 16'h5D4C;
    localparam logic [15:0] XOR_EXP2 = 16'h5D4C;
`endif

    logic16_arbiter #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in0_valid (in0_valid),
        .in0_ready (in0_ready),
        .in0_op    (in0_op),
        .in0_a     (in0_a),
        .in0_b     (in0_b),
        .in1_valid (in1_valid),
        .in1_ready (in1_ready),
        .in1_op    (in1_op),
        .in1_a     (in1_a),
        .in1_b     (in1_b),
        .out       (out),
        .out_id    (out_id),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_op(input int op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            1:       return a & b;
            2:       return a | b;
`ifdef LOGIC16_XOR_EN
            3:       return a ^ b;
`endif
            default: return ~a;
        endcase
    endfunction

    task automatic model_reset();
        m_full = 0;
        m_out  = 16'h0;
        m_id   = 0;
        m_ptr  = 0;
    endtask

    // One clock cycle: apply inputs, compare outputs and readies to the model, advance.
    task automatic cycle(input bit v0, input logic [1:0] op0, input logic [15:0] a0, input logic [15:0] b0,
                         input bit v1, input logic [1:0] op1, input logic [15:0] a1, input logic [15:0] b1,
                         input bit ordy);
        bit winner;
        bit acc;
        in0_valid = v0; in0_op = op0; in0_a = a0; in0_b = b0;
        in1_valid = v1; in1_op = op1; in1_a = a1; in1_b = b1;
        out_ready = ordy;
        #1;
        check("out_valid", {31'b0, out_valid}, {31'b0, m_full});
        check("out", {16'b0, out}, {16'b0, m_out});
        check("out_id", {31'b0, out_id}, {31'b0, m_id});
        winner = (v0 && v1) ? m_ptr : v1;
        acc    = (v0 || v1) && (!m_full || ordy);
        check("in0_ready", {31'b0, in0_ready}, {31'b0, acc && !winner});
        check("in1_ready", {31'b0, in1_ready}, {31'b0, acc && winner});
        last_r0 = in0_ready;
        last_r1 = in1_ready;
        if (acc) begin
            m_out  = winner ? ref_op(int'(op1), a1, b1) : ref_op(int'(op0), a0, b0);
            m_id   = winner;
            m_full = 1;
            m_ptr  = !winner;
        end else if (ordy) begin
            m_full = 0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        in0_valid = 1'b1; in0_op = 2'd0; in0_a = 16'h1234; in0_b = 16'h0;
        in1_valid = 1'b1; in1_op = 2'd0; in1_a = 16'h4321; in1_b = 16'h0;
        out_ready = 1'b1;
        model_reset();
        #1;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out", {16'b0, out}, 32'd0);
        check("rst_out_id", {31'b0, out_id}, 32'd0);
        check("rst_in0_ready", {31'b0, in0_ready}, 32'd0);
        check("rst_in1_ready", {31'b0, in1_ready}, 32'd0);
        @(posedge clk);
        #1;
        check("rst_edge_out_valid", {31'b0, out_valid}, 32'd0);
        rst = 1'b0;

        // contention: in0 preferred after reset, then in1
        cycle(1, 2'd1, 16'hF0F0, 16'h0FF0, 1, 2'd2, 16'h000F, 16'h0A00, 1);
        check("cont0_out", {16'b0, out}, 32'h00F0);
        check("cont0_id", {31'b0, out_id}, 32'd0);
        cycle(1, 2'd1, 16'hF0F0, 16'h0FF0, 1, 2'd2, 16'h000F, 16'h0A00, 1);
        check("cont1_out", {16'b0, out}, 32'h0A0F);
        check("cont1_id", {31'b0, out_id}, 32'd1);

        // single NOT
        cycle(1, 2'd0, 16'b0000001011110011, 16'h0, 0, 2'd0, 16'h0, 16'h0, 1);
        check("not_out", {16'b0, out}, {16'b0, 16'b1111110100001100});
        check("not_id", {31'b0, out_id}, 32'd0);
        check("not_valid", {31'b0, out_valid}, 32'd1);

        // backpressure on a held 5555 result
        cycle(1, 2'd2, 16'h5555, 16'h0000, 0, 2'd0, 16'h0, 16'h0, 1);
        for (int i = 0; i < 3; i++) begin
            cycle(1, 2'd1, 16'hAAAA, 16'hFFFF, 1, 2'd2, 16'h1111, 16'h2222, 0);
            check("bp_r0", {31'b0, last_r0}, 32'd0);
            check("bp_r1", {31'b0, last_r1}, 32'd0);
            check("bp_out", {16'b0, out}, 32'h5555);
        end
        cycle(0, 2'd0, 16'h0, 16'h0, 1, 2'd0, 16'h0000, 16'h0, 1);
        check("bp_release_r1", {31'b0, last_r1}, 32'd1);

        // throughput: four back-to-back results
        for (int i = 0; i < 4; i++) begin
            cycle(0, 2'd0, 16'h0, 16'h0, 1, 2'd0, 16'h0000, 16'h0, 1);
            check("tp_r1", {31'b0, last_r1}, 32'd1);
            check("tp_out", {16'b0, out}, 32'hFFFF);
            check("tp_id", {31'b0, out_id}, 32'd1);
            check("tp_valid", {31'b0, out_valid}, 32'd1);
        end

        // op 3 with and without XOR support
        cycle(1, 2'd3, 16'hA2B3, 16'hFFFF, 0, 2'd0, 16'h0, 16'h0, 1);
        check("xor_b_ffff", {16'b0, out}, {16'b0, XOR_EXP1});
        cycle(1, 2'd3, 16'hA2B3, 16'h0000, 0, 2'd0, 16'h0, 16'h0, 1);
        check("xor_b_0000", {16'b0, out}, {16'b0, XOR_EXP2});

        // asynchronous reset while a result is held; pointer currently prefers in1
        cycle(1, 2'd1, 16'hFFFF, 16'hFFFF, 0, 2'd0, 16'h0, 16'h0, 0);
        check("mid_valid_before", {31'b0, out_valid}, 32'd1);
        in1_valid = 1'b1;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        check("mid_rst_out", {16'b0, out}, 32'd0);
        check("mid_rst_id", {31'b0, out_id}, 32'd0);
        check("mid_rst_r0", {31'b0, in0_ready}, 32'd0);
        check("mid_rst_r1", {31'b0, in1_ready}, 32'd0);
        rst = 1'b0;
        #1;
        model_reset();
        cycle(1, 2'd2, 16'h00FF, 16'h0F00, 1, 2'd1, 16'hFFFF, 16'h00FF, 1);
        check("mid_ptr_r0", {31'b0, last_r0}, 32'd1);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cycle(1'($urandom_range(0, 1)), 2'($urandom), 16'($urandom), 16'($urandom),
                  1'($urandom_range(0, 1)), 2'($urandom), 16'($urandom), 16'($urandom),
                  ($urandom_range(0, 3) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/logic16_arbiter.md
LOGIC16_ARBITER -- requirements
Module: logic16_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 16, datapath width in bits.
REQ-002 SHALL have port clk, input, 1, sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-004 SHALL have ports in0_valid / in1_valid, input, 1 each, requester 0/1 has an operation pending.
REQ-005 SHALL have ports in0_ready / in1_ready, output, 1 each, requester 0/1 operation accepted this cycle.
REQ-006 SHALL have ports in0_op / in1_op, input, 2 each, operation: 0=NOT a, 1=AND, 2=OR, 3=XOR.
REQ-007 SHALL have ports in0_a, in0_b, in1_a, in1_b, input, WIDTH each, operands; b is ignored for NOT.
REQ-008 SHALL have port out, output, WIDTH, registered result.
REQ-009 SHALL have port out_id, output, 1, index of the requester that owns out.
REQ-010 SHALL have port out_valid, output, 1, out/out_id hold a result.
REQ-011 SHALL have port out_ready, input, 1, consumer takes the result.

Function
REQ-012 SHALL share one WIDTH-bit logic unit between two requesters; at most one operation accepted per cycle.
REQ-013 SHALL accept (can_accept=1) when out_valid=0, or when out_valid=1 and out_ready=1 in the same cycle.
REQ-014 SHALL assert inN_ready only when can_accept=1, inN_valid=1 and requester N is granted; ready is combinational and never asserted without valid.
REQ-015 SHALL grant round-robin: a 1-bit priority pointer names the preferred requester; a lone valid requester is always granted.
REQ-016 SHALL, after every accepted operation from requester N, set the pointer to the other requester.
REQ-017 SHALL leave the pointer unchanged in cycles with no accepted operation.
REQ-018 SHALL register the result: out = f(op,a,b), out_id = N, out_valid = 1 on the edge after acceptance, which is one-cycle latency.
REQ-019 SHALL hold out, out_id and out_valid stable while out_valid=1 and out_ready=0.
REQ-020 SHALL clear out_valid when out_ready=1 and no new operation is accepted in that cycle, and leave out unchanged.
REQ-021 SHALL sustain one result per cycle when out_ready is held at 1 and requests are continuous.
REQ-022 SHALL ignore the inputs of a requester whose valid is low; operand changes without a handshake have no effect.
REQ-023 SHALL have a two-state controller, EMPTY (out_valid=0) and FULL (out_valid=1):
- EMPTY->FULL on accept.
- FULL->FULL on accept or when out_ready=0.
- FULL->EMPTY on out_ready=1 with no accept.

Reset
REQ-024 SHALL, while rst=1, force out=0, out_id=0, out_valid=0, pointer=0 (requester 0 preferred), and in0_ready=in1_ready=0.
REQ-025 SHALL, when rst is asserted mid-transfer, discard any held result; no handshake completes in a cycle where rst=1.

Configuration
REQ-026 SHALL gate XOR with macro LOGIC16_XOR_EN: defined -> op 3 yields a^b; undefined -> op 3 yields NOT a, and no XOR logic is instantiated.

Structure
REQ-027 SHALL place WIDTH default, op encodings (OP_NOT, OP_AND, OP_OR, OP_XOR) and state encodings in shared package logic16_pkg.
REQ-028 SHALL implement the combinational operation in sub-module logic16_unit (op, a, b -> y); the arbiter instantiates it once.

Verification
REQ-029 SHALL cover these directed scenarios:
- Single NOT: in0 op=0, a=16'b0000001011110011 -> next cycle out=16'b1111110100001100, out_id=0, out_valid=1.
- Contention: both valid, pointer=0, in0 AND 16'hF0F0 & 16'h0FF0, in1 OR 16'h000F | 16'h0A00 -> in0 granted first with out=16'h00F0, in1 next cycle with out=16'h0A0F, out_id=1.
- Backpressure: out_ready=0 for 3 cycles with result 16'h5555 held -> out stable, in0_ready=in1_ready=0 throughout; out_ready=1 -> new accept in that same cycle.
- Throughput: out_ready=1, in1 valid 4 cycles with NOT of 16'h0000 -> 4 consecutive results of 16'hFFFF, out_id=1.
- XOR config: op=3, a=16'hA2B3, b=16'hFFFF -> 16'h5D4C with LOGIC16_XOR_EN defined, 16'h5D4C (NOT a) without it; repeat with b=16'h0000 -> 16'hA2B3 vs 16'h5D4C.
- Reset mid-operation: rst pulsed while out_valid=1 -> out_valid=0, out=0, pointer=0 immediately, without waiting for a clock edge.
